mfp_reset_sequencer: RTL and testbench
======================================

// Module: mfp_reset_sequencer
// PURPOSE
//  Board-level reset controller for the MIPSfpga system on DE0-Nano; replaces the free-running reset counter.
//  Waits for a stable PLL lock, then drives the cold-reset pulse, then the warm-reset pulse, then releases
//  the core. Debounces KEY[0]: short press = warm reset, long press = cold reset. Loss of lock restarts it.
//  Runs in the 10 MHz core clock domain and drives SI_ColdReset, SI_Reset and debug LEDs.
// PARAMETERS
//  SYNC_STAGES        2         synchroniser depth for key_n and pll_locked (>=2)
//  DEBOUNCE_CYCLES    10000     cycles the synced key must hold its value to be accepted (1 ms @10 MHz)
//  LOCK_STABLE_CYCLES 256       consecutive synced-locked cycles required before leaving WAIT_LOCK
//  COLD_CYCLES        32        cycles spent in COLD (cold_reset=1, sys_reset=1)
//  WARM_CYCLES        32        cycles spent in WARM (cold_reset=0, sys_reset=1)
//  LONG_PRESS_CYCLES  20000000  debounced hold time that escalates a press to a cold reset (2 s)
// PORTS
//  clk         in   1  core clock (PLL c0, 10 MHz)
//  reset       in   1  block reset
//  pll_locked  in   1  PLL lock, asynchronous, synchronised internally
//  key_n       in   1  push button, active-low, asynchronous, bouncing
//  cold_reset  out  1  to SI_ColdReset, active-high
//  sys_reset   out  1  to SI_Reset, active-high
//  run         out  1  1 only in state RUN
//  cause       out  2  last reset cause: 0 power/lock, 1 short press, 2 long press; 3 unused
// BEHAVIOUR
//  Interface: reset is synchronous, active-high; clock is clk. All outputs registered.
//  Reset values: cold_reset=1, sys_reset=1, run=0, cause=0; state WAIT_LOCK; all counters 0; debounced key=released.
//  States / outputs (cold_reset, sys_reset, run):
//   WAIT_LOCK (1,1,0): lock_cnt++ while synced lock=1, cleared when 0; lock_cnt==LOCK_STABLE_CYCLES-1 -> COLD.
//   COLD      (1,1,0): phase_cnt counts COLD_CYCLES, then -> WARM.
//   WARM      (0,1,0): phase_cnt counts WARM_CYCLES, then -> RUN.
//   RUN       (0,0,0→1): run=1; rising edge of debounced "pressed" -> PRESS, press_cnt=0.
//   PRESS     (0,1,0): core held in warm reset while held; release before LONG -> WARM, cause=1;
//             press_cnt==LONG_PRESS_CYCLES-1 -> COLD, cause=2.
//  Priority each cycle: reset > synced lock==0 (any state except WAIT_LOCK -> WAIT_LOCK, lock_cnt=0, cause=0)
//   > phase/press transitions.
//  Lock-loss entry to WAIT_LOCK sets cold_reset=sys_reset=1 on the next edge.
//  Debounce: synced key compared with stable value; mismatch increments deb_cnt, match clears it;
//   deb_cnt==DEBOUNCE_CYCLES-1 -> stable value updated, deb_cnt cleared.
//  Only a released->pressed edge leaves RUN; a button still held after COLD/WARM does not retrigger.
//  Presses in WAIT_LOCK/COLD/WARM are ignored (debouncer still tracks; no edge is latched).
//  Counter widths are $clog2(param)+1; counters never wrap (cleared on every state entry).
//  Power-up latency, lock stable from t0: SYNC_STAGES+LOCK_STABLE_CYCLES cycles -> COLD;
//   cold_reset falls after +COLD_CYCLES; sys_reset falls after a further +WARM_CYCLES.
// STRUCTURE
//  Shared header mfp_reset_defs: state encodings (WAIT_LOCK, COLD, WARM, RUN, PRESS) and CAUSE_* constants.
//  Sub-module mfp_debounce (synchroniser + debounce counter, params SYNC_STAGES, DEBOUNCE_CYCLES),
//   instanced for key_n. pll_locked uses a bare SYNC_STAGES synchroniser; no debounce.
//  Top FSM, phase/press counters and output registers live in mfp_reset_sequencer.
// TESTING (bench params: SYNC=2, DEBOUNCE=4, LOCK_STABLE=8, COLD=4, WARM=4, LONG=50)
//  Power-up: reset 3 cycles, pll_locked=1 -> cold_reset falls at cycle 14, sys_reset at 18, run=1, cause=0.
//  Lock glitch: pll_locked low 1 cycle during WAIT_LOCK at lock_cnt=5 -> lock_cnt restarts, COLD entry delayed.
//  Short press: in RUN, key_n low 20 cycles with 3-cycle bounce at edges -> one PRESS/WARM, cause=1, run back.
//  Long press: key_n low 80 cycles -> COLD after 50 held cycles, cause=2; no retrigger while still held.
//  Bounce reject: key_n toggled every 2 cycles for 40 cycles -> debounced key stays released, run stays 1.
//  Lock loss in RUN and reset mid-COLD -> both outputs 1 next cycle, state WAIT_LOCK, full sequence repeats.

Source files
------------

// File: rtl/mfp_reset_sequencer_pkg.sv
// Shared state encodings, reset-cause codes and counter sizing for the board reset sequencer.
package mfp_reset_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_LOCK = 3'd0,
        ST_COLD      = 3'd1,
        ST_WARM      = 3'd2,
        ST_RUN       = 3'd3,
        ST_PRESS     = 3'd4
    } state_t;

    localparam logic [1:0] CAUSE_POWER = 2'd0;
    localparam logic [1:0] CAUSE_SHORT = 2'd1;
    localparam logic [1:0] CAUSE_LONG  = 2'd2;

    // One spare bit so a terminal compare against n-1 never needs a wrap.
    function automatic int cnt_width(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/mfp_debounce.sv
// Synchroniser plus hold-time debouncer: stable follows din once the synced value has disagreed
// with it for DEBOUNCE_CYCLES consecutive cycles (SYNC_STAGES + DEBOUNCE_CYCLES cycles latency).
module mfp_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 10000,
    parameter bit IDLE_LEVEL      = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic stable
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;

    logic [SYNC_STAGES-1:0] sync;
    logic [DW-1:0]          deb_cnt;
    logic                   synced;

    assign synced = sync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            sync    <= {SYNC_STAGES{IDLE_LEVEL}};
            deb_cnt <= '0;
            stable  <= IDLE_LEVEL;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], din};
            if (synced == stable) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
                stable  <= synced;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + DW'(1);
            end
        end
    end

endmodule

// File: rtl/mfp_reset_sequencer.sv
// Board reset sequencer: stable PLL lock -> cold pulse -> warm pulse -> run; KEY[0] short press
// re-runs warm reset, long press re-runs cold reset; lock loss restarts the whole sequence.
module mfp_reset_sequencer
    import mfp_reset_sequencer_pkg::*;
#(
    parameter int SYNC_STAGES        = 2,
    parameter int DEBOUNCE_CYCLES    = 10000,
    parameter int LOCK_STABLE_CYCLES = 256,
    parameter int COLD_CYCLES        = 32,
    parameter int WARM_CYCLES        = 32,
    parameter int LONG_PRESS_CYCLES  = 20000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pll_locked,
    input  logic       key_n,
    output logic       cold_reset,
    output logic       sys_reset,
    output logic       run,
    output logic [1:0] cause
);

    localparam int PHASE_MAX = (COLD_CYCLES > WARM_CYCLES) ? COLD_CYCLES : WARM_CYCLES;
    localparam int LW = cnt_width(LOCK_STABLE_CYCLES);
    localparam int PW = cnt_width(PHASE_MAX);
    localparam int KW = cnt_width(LONG_PRESS_CYCLES);

    state_t                 state;
    logic [SYNC_STAGES-1:0] lock_sync;
    logic                   locked;
    logic                   key_stable;
    logic                   pressed;
    logic                   pressed_q;
    logic [LW-1:0]          lock_cnt;
    logic [PW-1:0]          phase_cnt;
    logic [KW-1:0]          press_cnt;

    mfp_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .IDLE_LEVEL      (1'b1)
    ) u_key_debounce (
        .clk    (clk),
        .reset  (reset),
        .din    (key_n),
        .stable (key_stable)
    );

    assign locked  = lock_sync[SYNC_STAGES-1];
    assign pressed = ~key_stable;

    always_ff @(posedge clk) begin
        if (reset) begin
            lock_sync <= '0;
        end else begin
            lock_sync <= {lock_sync[SYNC_STAGES-2:0], pll_locked};
        end
    end

    // pressed_q tracks every cycle so a press that matured outside RUN never shows up as an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_WAIT_LOCK;
            lock_cnt   <= '0;
            phase_cnt  <= '0;
            press_cnt  <= '0;
            pressed_q  <= 1'b0;
            cold_reset <= 1'b1;
            sys_reset  <= 1'b1;
            run        <= 1'b0;
            cause      <= CAUSE_POWER;
        end else begin
            pressed_q <= pressed;
            if (!locked && state != ST_WAIT_LOCK) begin
                state      <= ST_WAIT_LOCK;
                lock_cnt   <= '0;
                cause      <= CAUSE_POWER;
                cold_reset <= 1'b1;
                sys_reset  <= 1'b1;
                run        <= 1'b0;
            end else begin
                case (state)
                    ST_WAIT_LOCK: begin
                        if (!locked) begin
                            lock_cnt <= '0;
                        end else if (lock_cnt == LW'(LOCK_STABLE_CYCLES - 1)) begin
                            state     <= ST_COLD;
                            lock_cnt  <= '0;
                            phase_cnt <= '0;
                        end else begin
                            lock_cnt <= lock_cnt + LW'(1);
                        end
                    end
                    ST_COLD: begin
                        if (phase_cnt == PW'(COLD_CYCLES - 1)) begin
                            state      <= ST_WARM;
                            phase_cnt  <= '0;
                            cold_reset <= 1'b0;
                        end else begin
                            phase_cnt <= phase_cnt + PW'(1);
                        end
                    end
                    ST_WARM: begin
                        if (phase_cnt == PW'(WARM_CYCLES - 1)) begin
                            state     <= ST_RUN;
                            phase_cnt <= '0;
                            sys_reset <= 1'b0;
                            run       <= 1'b1;
                        end else begin
                            phase_cnt <= phase_cnt + PW'(1);
                        end
                    end
                    ST_RUN: begin
                        if (pressed && !pressed_q) begin
                            state     <= ST_PRESS;
                            press_cnt <= '0;
                            sys_reset <= 1'b1;
                            run       <= 1'b0;
                        end
                    end
                    ST_PRESS: begin
                        if (!pressed) begin
                            state     <= ST_WARM;
                            phase_cnt <= '0;
                            cause     <= CAUSE_SHORT;
                        end else if (press_cnt == KW'(LONG_PRESS_CYCLES - 1)) begin
                            state      <= ST_COLD;
                            phase_cnt  <= '0;
                            cold_reset <= 1'b1;
                            cause      <= CAUSE_LONG;
                        end else begin
                            press_cnt <= press_cnt + KW'(1);
                        end
                    end
                    default: begin
                        state      <= ST_WAIT_LOCK;
                        lock_cnt   <= '0;
                        cold_reset <= 1'b1;
                        sys_reset  <= 1'b1;
                        run        <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mfp_reset_sequencer.sv
// Bench for mfp_reset_sequencer: expected output changes are queued with their exact cycle and
// matched against the changes the monitor records on the falling edge.
module tb_mfp_reset_sequencer;

    localparam int SYNC  = 2;
    localparam int DEB   = 4;
    localparam int LOCK  = 8;
    localparam int COLD  = 4;
    localparam int WARM  = 4;
    localparam int LONG  = 50;
    localparam int OBS_N = 128;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pll_locked = 1'b1;
    logic       key_n = 1'b1;
    logic       cold_reset;
    logic       sys_reset;
    logic       run;
    logic [1:0] cause;

    mfp_reset_sequencer #(
        .SYNC_STAGES        (SYNC),
        .DEBOUNCE_CYCLES    (DEB),
        .LOCK_STABLE_CYCLES (LOCK),
        .COLD_CYCLES        (COLD),
        .WARM_CYCLES        (WARM),
        .LONG_PRESS_CYCLES  (LONG)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pll_locked (pll_locked),
        .key_n      (key_n),
        .cold_reset (cold_reset),
        .sys_reset  (sys_reset),
        .run        (run),
        .cause      (cause)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: log every change of {cold_reset, sys_reset, run, cause} with its cycle number.
    logic [4:0] obs_vec [0:OBS_N-1];
    int         obs_cyc [0:OBS_N-1];
    int         obs_wr = 0;
    logic       mon_en = 1'b0;
    logic [4:0] prev;
    logic [4:0] cur;
    assign cur = {cold_reset, sys_reset, run, cause};

    always @(negedge clk) begin
        if (!mon_en) begin
            prev <= cur;
        end else if (cur !== prev && obs_wr < OBS_N) begin
            obs_vec[obs_wr] <= cur;
            obs_cyc[obs_wr] <= cyc;
            obs_wr          <= obs_wr + 1;
            prev            <= cur;
        end
    end

    typedef struct {
        logic [4:0] vec;
        int         at;
    } exp_t;

    exp_t exp_q[$];
    int   obs_rd = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic expect_change(input logic [4:0] vec, input int at);
        exp_t e;
        e.vec = vec;
        e.at  = at;
        exp_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        tick(3);
        @(negedge clk);
        n_cmp++; if (cold_reset !== 1'b1) begin n_err++; $display("FAIL reset cold_reset: got %b want 1", cold_reset); end
        n_cmp++; if (sys_reset !== 1'b1)  begin n_err++; $display("FAIL reset sys_reset: got %b want 1", sys_reset); end
        n_cmp++; if (run !== 1'b0)        begin n_err++; $display("FAIL reset run: got %b want 0", run); end
        n_cmp++; if (cause !== 2'd0)      begin n_err++; $display("FAIL reset cause: got %0d want 0", cause); end
        mon_en = 1'b1;
    endtask

    task automatic test_power_up;
        int base;
        exp_t e;
        @(posedge clk); #1;
        base  = cyc;
        reset = 1'b0;
        expect_change(5'b01000, base + 14);
        expect_change(5'b00100, base + 18);
        for (int t = 0; t < 300 && (obs_wr - obs_rd) < exp_q.size(); t++) tick(1);
        tick(6);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_rd >= obs_wr) begin n_err++; $display("FAIL power_up: no change seen, want %b at cycle %0d", e.vec, e.at - base); end
            else begin
                if (obs_vec[obs_rd] !== e.vec || obs_cyc[obs_rd] != e.at) begin
                    n_err++; $display("FAIL power_up: got %b at cycle %0d, want %b at cycle %0d", obs_vec[obs_rd], obs_cyc[obs_rd] - base, e.vec, e.at - base);
                end
                obs_rd++;
            end
        end
        n_cmp++; if (obs_wr != obs_rd) begin n_err++; $display("FAIL power_up extra: %0d unexpected changes, want 0", obs_wr - obs_rd); obs_rd = obs_wr; end
    endtask

    task automatic test_short_press;
        int t0;
        exp_t e;
        @(posedge clk); #1;
        t0 = cyc;
        // 0,1 bounce, 21 cycles low, 1,0 bounce, then released
        for (int i = 0; i < 26; i++) begin
            key_n = (i == 1 || i == 23 || i == 25) ? 1'b1 : 1'b0;
            tick(1);
        end
        expect_change(5'b01000, t0 + 9);
        expect_change(5'b01001, t0 + 32);
        expect_change(5'b00101, t0 + 36);
        for (int t = 0; t < 300 && (obs_wr - obs_rd) < exp_q.size(); t++) tick(1);
        tick(12);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_rd >= obs_wr) begin n_err++; $display("FAIL short_press: no change seen, want %b at +%0d", e.vec, e.at - t0); end
            else begin
                if (obs_vec[obs_rd] !== e.vec || obs_cyc[obs_rd] != e.at) begin
                    n_err++; $display("FAIL short_press: got %b at +%0d, want %b at +%0d", obs_vec[obs_rd], obs_cyc[obs_rd] - t0, e.vec, e.at - t0);
                end
                obs_rd++;
            end
        end
        n_cmp++; if (obs_wr != obs_rd) begin n_err++; $display("FAIL short_press extra: %0d unexpected changes, want 0", obs_wr - obs_rd); obs_rd = obs_wr; end
    endtask

    task automatic test_long_press;
        int t0;
        exp_t e;
        @(posedge clk); #1;
        t0    = cyc;
        key_n = 1'b0;
        expect_change(5'b01001, t0 + 7);
        expect_change(5'b11010, t0 + 7 + LONG);
        expect_change(5'b01010, t0 + 7 + LONG + COLD);
        expect_change(5'b00110, t0 + 7 + LONG + COLD + WARM);
        tick(80);
        key_n = 1'b1;
        tick(20);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_rd >= obs_wr) begin n_err++; $display("FAIL long_press: no change seen, want %b at +%0d", e.vec, e.at - t0); end
            else begin
                if (obs_vec[obs_rd] !== e.vec || obs_cyc[obs_rd] != e.at) begin
                    n_err++; $display("FAIL long_press: got %b at +%0d, want %b at +%0d", obs_vec[obs_rd], obs_cyc[obs_rd] - t0, e.vec, e.at - t0);
                end
                obs_rd++;
            end
        end
        n_cmp++; if (obs_wr != obs_rd) begin n_err++; $display("FAIL long_press retrigger: %0d unexpected changes, want 0", obs_wr - obs_rd); obs_rd = obs_wr; end
        @(negedge clk);
        n_cmp++; if (run !== 1'b1) begin n_err++; $display("FAIL long_press run after release: got %b want 1", run); end
    endtask

    task automatic test_bounce_reject;
        for (int i = 0; i < 40; i++) begin
            key_n = ((i / 2) % 2 == 1) ? 1'b1 : 1'b0;
            tick(1);
        end
        key_n = 1'b1;
        tick(12);
        @(negedge clk);
        n_cmp++; if (run !== 1'b1) begin n_err++; $display("FAIL bounce run: got %b want 1", run); end
        n_cmp++; if (obs_wr != obs_rd) begin n_err++; $display("FAIL bounce: %0d output changes, want 0", obs_wr - obs_rd); obs_rd = obs_wr; end
    endtask

    task automatic test_lock_loss;
        int g;
        int h;
        exp_t e;
        @(posedge clk); #1;
        g          = cyc;
        pll_locked = 1'b0;
        expect_change(5'b11000, g + 3);
        tick(10);
        h          = cyc;
        pll_locked = 1'b1;
        expect_change(5'b01000, h + 14);
        expect_change(5'b00100, h + 18);
        for (int t = 0; t < 300 && (obs_wr - obs_rd) < exp_q.size(); t++) tick(1);
        tick(6);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_rd >= obs_wr) begin n_err++; $display("FAIL lock_loss: no change seen, want %b at +%0d", e.vec, e.at - g); end
            else begin
                if (obs_vec[obs_rd] !== e.vec || obs_cyc[obs_rd] != e.at) begin
                    n_err++; $display("FAIL lock_loss: got %b at +%0d, want %b at +%0d", obs_vec[obs_rd], obs_cyc[obs_rd] - g, e.vec, e.at - g);
                end
                obs_rd++;
            end
        end
        n_cmp++; if (obs_wr != obs_rd) begin n_err++; $display("FAIL lock_loss extra: %0d unexpected changes, want 0", obs_wr - obs_rd); obs_rd = obs_wr; end
    endtask

    task automatic test_reset_mid_cold;
        int r;
        int base;
        exp_t e;
        @(posedge clk); #1;
        r     = cyc;
        reset = 1'b1;
        expect_change(5'b11000, r + 1);
        tick(1);
        reset = 1'b0;
        tick(11);
        reset = 1'b1;
        tick(2);
        @(negedge clk);
        n_cmp++; if (cold_reset !== 1'b1 || sys_reset !== 1'b1) begin n_err++; $display("FAIL mid_cold held: got cold=%b sys=%b want 1 1", cold_reset, sys_reset); end
        @(posedge clk); #1;
        base  = cyc;
        reset = 1'b0;
        expect_change(5'b01000, base + 14);
        expect_change(5'b00100, base + 18);
        for (int t = 0; t < 300 && (obs_wr - obs_rd) < exp_q.size(); t++) tick(1);
        tick(6);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_rd >= obs_wr) begin n_err++; $display("FAIL mid_cold: no change seen, want %b at cycle %0d", e.vec, e.at - r); end
            else begin
                if (obs_vec[obs_rd] !== e.vec || obs_cyc[obs_rd] != e.at) begin
                    n_err++; $display("FAIL mid_cold: got %b at +%0d, want %b at +%0d", obs_vec[obs_rd], obs_cyc[obs_rd] - r, e.vec, e.at - r);
                end
                obs_rd++;
            end
        end
        n_cmp++; if (obs_wr != obs_rd) begin n_err++; $display("FAIL mid_cold extra: %0d unexpected changes, want 0", obs_wr - obs_rd); obs_rd = obs_wr; end
    endtask

    task automatic test_lock_glitch;
        int r;
        int base;
        exp_t e;
        @(posedge clk); #1;
        r     = cyc;
        reset = 1'b1;
        expect_change(5'b11000, r + 1);
        tick(3);
        base  = cyc;
        reset = 1'b0;
        tick(5);
        pll_locked = 1'b0;
        tick(1);
        pll_locked = 1'b1;
        // synced low seen with lock_cnt=5, so COLD entry slips from +10 to +16
        expect_change(5'b01000, base + 20);
        expect_change(5'b00100, base + 24);
        for (int t = 0; t < 300 && (obs_wr - obs_rd) < exp_q.size(); t++) tick(1);
        tick(6);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_rd >= obs_wr) begin n_err++; $display("FAIL lock_glitch: no change seen, want %b at +%0d", e.vec, e.at - base); end
            else begin
                if (obs_vec[obs_rd] !== e.vec || obs_cyc[obs_rd] != e.at) begin
                    n_err++; $display("FAIL lock_glitch: got %b at +%0d, want %b at +%0d", obs_vec[obs_rd], obs_cyc[obs_rd] - base, e.vec, e.at - base);
                end
                obs_rd++;
            end
        end
        n_cmp++; if (obs_wr != obs_rd) begin n_err++; $display("FAIL lock_glitch extra: %0d unexpected changes, want 0", obs_wr - obs_rd); obs_rd = obs_wr; end
    endtask

    initial begin
        test_reset;
        test_power_up;
        test_short_press;
        test_long_press;
        test_bounce_reject;
        test_lock_loss;
        test_reset_mid_cold;
        test_lock_glitch;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
